// File: rtl/multiply_unit_pkg.sv
// Shared operation encodings, FSM states and type-decode helpers for multiply_unit.
package multiply_unit_pkg;

    typedef enum logic [2:0] {
        OP_MUL   = 3'b000,
        OP_MLA   = 3'b001,
        OP_UMULL = 3'b100,
        OP_UMLAL = 3'b101,
        OP_SMULL = 3'b110,
        OP_SMLAL = 3'b111
    } op_e;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_MUL,
        ST_FIX,
        ST_DONE
    } state_e;

    // 010/011 have no defined operation.
    function automatic logic op_undef(input logic [2:0] op);
        return op[2:1] == 2'b01;
    endfunction

    function automatic logic op_long(input logic [2:0] op);
        return op[2];
    endfunction

    function automatic logic op_signed(input logic [2:0] op);
        return op[2] & op[1];
    endfunction

    function automatic logic op_acc(input logic [2:0] op);
        return op[0];
    endfunction

endpackage

// File: rtl/multiply_unit_mul_step.sv
// Combinational step: adds mcand * bits, shifted left by shamt, into a 2*WIDTH partial sum.
module mul_step #(
    parameter int WIDTH     = 32,
    parameter int STEP_BITS = 8,
    parameter int SHW       = 6
) (
    input  logic [WIDTH-1:0]     mcand_i,
    input  logic [STEP_BITS-1:0] bits_i,
    input  logic [SHW-1:0]       shamt_i,
    input  logic [2*WIDTH-1:0]   acc_i,
    output logic [2*WIDTH-1:0]   sum_o
);

    logic [2*WIDTH-1:0] pp;

    always_comb begin
        pp = '0;
        for (int i = 0; i < STEP_BITS; i++) begin
            if (bits_i[i]) begin
                pp = pp + ({{WIDTH{1'b0}}, mcand_i} << i);
            end
        end
        sum_o = acc_i + (pp << shamt_i);
    end

endmodule

// File: rtl/multiply_unit.sv
// Iterative multiplier / multiply-accumulate: STEP_BITS of |b| per cycle, sign fix and accumulate in FIX.
// Latency N+2 cycles from accepting edge to done (2 for undefined types); start is ignored while busy.
module multiply_unit
    import multiply_unit_pkg::*;
#(
    parameter int WIDTH      = 32,
    parameter int STEP_BITS  = 8,
    parameter int EARLY_TERM = 0
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               start,
    input  logic               flush,
    input  logic [2:0]         type_i,
    input  logic [WIDTH-1:0]   a,
    input  logic [WIDTH-1:0]   b,
    input  logic [WIDTH-1:0]   c,
    input  logic [WIDTH-1:0]   d,
    output logic               busy,
    output logic               done,
    output logic [2*WIDTH-1:0] result,
    output logic               n,
    output logic               z,
    output logic               undef
);

    localparam int N   = WIDTH / STEP_BITS;
    localparam int CW  = (N > 1) ? $clog2(N) : 1;
    localparam int SHW = $clog2(2 * WIDTH);

    state_e             state_q, state_d;
    logic [CW-1:0]      cnt_q, cnt_d;
    logic [2:0]         op_q, op_d;
    logic               neg_q, neg_d;
    logic [WIDTH-1:0]   mcand_q, mcand_d;
    logic [WIDTH-1:0]   mplier_q, mplier_d;
    logic [2*WIDTH-1:0] acc_q, acc_d;
    logic [2*WIDTH-1:0] accin_q, accin_d;
    logic [2*WIDTH-1:0] result_q, result_d;
    logic               n_q, n_d, z_q, z_d, undef_q, undef_d;

    logic               sa, sb;
    logic [WIDTH-1:0]   mag_a, mag_b, mplier_next;
    logic [SHW-1:0]     shamt;
    logic [2*WIDTH-1:0] step_sum, fixed, total;

    assign shamt = SHW'(cnt_q) * SHW'(STEP_BITS);

    mul_step #(
        .WIDTH     (WIDTH),
        .STEP_BITS (STEP_BITS),
        .SHW       (SHW)
    ) u_step (
        .mcand_i (mcand_q),
        .bits_i  (mplier_q[STEP_BITS-1:0]),
        .shamt_i (shamt),
        .acc_i   (acc_q),
        .sum_o   (step_sum)
    );

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        op_d     = op_q;
        neg_d    = neg_q;
        mcand_d  = mcand_q;
        mplier_d = mplier_q;
        acc_d    = acc_q;
        accin_d  = accin_q;
        result_d = result_q;
        n_d      = n_q;
        z_d      = z_q;
        undef_d  = undef_q;

        sa          = op_signed(type_i) & a[WIDTH-1];
        sb          = op_signed(type_i) & b[WIDTH-1];
        mag_a       = sa ? (WIDTH'(0) - a) : a;
        mag_b       = sb ? (WIDTH'(0) - b) : b;
        mplier_next = mplier_q >> STEP_BITS;
        fixed       = neg_q ? ((2*WIDTH)'(0) - acc_q) : acc_q;
        total       = fixed + accin_q;

        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    op_d     = type_i;
                    neg_d    = sa ^ sb;
                    mcand_d  = mag_a;
                    mplier_d = mag_b;
                    cnt_d    = '0;
                    acc_d    = '0;
                    if (!op_acc(type_i))      accin_d = '0;
                    else if (op_long(type_i)) accin_d = {c, d};
                    else                      accin_d = {{WIDTH{1'b0}}, c};
                    state_d  = op_undef(type_i) ? ST_FIX : ST_MUL;
                end
            end
            ST_MUL: begin
                acc_d    = step_sum;
                mplier_d = mplier_next;
                cnt_d    = cnt_q + CW'(1);
                if (cnt_q == CW'(N - 1) || (EARLY_TERM != 0 && mplier_next == '0)) begin
                    state_d = ST_FIX;
                end
            end
            ST_FIX: begin
                state_d = ST_DONE;
                if (op_undef(op_q)) begin
                    result_d = '0;
                    n_d      = 1'b0;
                    z_d      = 1'b1;
                    undef_d  = 1'b1;
                end else if (!op_long(op_q)) begin
                    result_d = {{WIDTH{1'b0}}, total[WIDTH-1:0]};
                    n_d      = total[WIDTH-1];
                    z_d      = (total[WIDTH-1:0] == '0);
                    undef_d  = 1'b0;
                end else begin
                    result_d = total;
                    n_d      = total[2*WIDTH-1];
                    z_d      = (total == '0);
                    undef_d  = 1'b0;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // A flushed operation never commits, even from FIX.
        if (flush) begin
            state_d  = ST_IDLE;
            result_d = result_q;
            n_d      = n_q;
            z_d      = z_q;
            undef_d  = undef_q;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= ST_IDLE;
            cnt_q    <= '0;
            op_q     <= '0;
            neg_q    <= 1'b0;
            mcand_q  <= '0;
            mplier_q <= '0;
            acc_q    <= '0;
            accin_q  <= '0;
            result_q <= '0;
            n_q      <= 1'b0;
            z_q      <= 1'b0;
            undef_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            op_q     <= op_d;
            neg_q    <= neg_d;
            mcand_q  <= mcand_d;
            mplier_q <= mplier_d;
            acc_q    <= acc_d;
            accin_q  <= accin_d;
            result_q <= result_d;
            n_q      <= n_d;
            z_q      <= z_d;
            undef_q  <= undef_d;
        end
    end

    assign busy   = (state_q != ST_IDLE);
    assign done   = (state_q == ST_DONE);
    assign result = result_q;
    assign n      = n_q;
    assign z      = z_q;
    assign undef  = undef_q;

endmodule

// File: tb/tb_multiply_unit.sv
// Randomized and directed bench for multiply_unit, default geometry (32-bit, 8 bits/step) with and without early exit.
module tb_multiply_unit;

    localparam int N = 4;

    logic        clk = 1'b0;
    logic        reset, start, flush;
    logic [2:0]  type_i;
    logic [31:0] a, b, c, d;
    logic        busy0, done0, n0, z0, u0;
    logic        busy1, done1, n1, z1, u1;
    logic [63:0] res0, res1;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    multiply_unit #(.WIDTH(32), .STEP_BITS(8), .EARLY_TERM(0)) dut (
        .clk(clk), .reset(reset), .start(start), .flush(flush), .type_i(type_i),
        .a(a), .b(b), .c(c), .d(d),
        .busy(busy0), .done(done0), .result(res0), .n(n0), .z(z0), .undef(u0)
    );

    multiply_unit #(.WIDTH(32), .STEP_BITS(8), .EARLY_TERM(1)) dut_et (
        .clk(clk), .reset(reset), .start(start), .flush(flush), .type_i(type_i),
        .a(a), .b(b), .c(c), .d(d),
        .busy(busy1), .done(done1), .result(res1), .n(n1), .z(z1), .undef(u1)
    );

    // Reference model: plain 64-bit arithmetic on sign- or zero-extended operands.
    function automatic logic [63:0] ref_result(input logic [2:0] op, input logic [31:0] ia, ib, ic, id);
        logic [63:0] ua, ub, sa, sb, p;
        ua = {32'b0, ia};
        ub = {32'b0, ib};
        sa = {{32{ia[31]}}, ia};
        sb = {{32{ib[31]}}, ib};
        case (op)
            3'b000:  p = (ua * ub) & 64'h0000_0000_FFFF_FFFF;
            3'b001:  p = (ua * ub + {32'b0, ic}) & 64'h0000_0000_FFFF_FFFF;
            3'b100:  p = ua * ub;
            3'b101:  p = ua * ub + {ic, id};
            3'b110:  p = sa * sb;
            3'b111:  p = sa * sb + {ic, id};
            default: p = 64'd0;
        endcase
        return p;
    endfunction

    function automatic logic ref_n(input logic [2:0] op, input logic [63:0] r);
        return op[2] ? r[63] : r[31];
    endfunction

    function automatic logic ref_z(input logic [2:0] op, input logic [63:0] r);
        return op[2] ? (r == 64'd0) : (r[31:0] == 32'd0);
    endfunction

    function automatic int ref_latency(input bit et, input logic [2:0] op, input logic [31:0] ib);
        logic [31:0] mag;
        int m;
        if (op[2:1] == 2'b01) return 2;
        if (!et) return N + 2;
        mag = (op[2] && op[1] && ib[31]) ? (32'd0 - ib) : ib;
        m = 1;
        for (int k = 1; k < N; k++) if ((mag >> (8 * k)) != 32'd0) m = k + 1;
        return m + 2;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic issue(input logic [2:0] op, input logic [31:0] ia, ib, ic, id);
        type_i = op; a = ia; b = ib; c = ic; d = id;
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    // Returns the cycle (counted from 'first') of the first done pulse and the number of pulses seen.
    task automatic wait_done(input bit et, input bit scramble, input int first, output int cyc, output int nd);
        logic dn;
        cyc = 0;
        nd  = 0;
        for (int i = first; i <= first + 40; i++) begin
            if (scramble) begin
                a = $urandom; b = $urandom; c = $urandom; d = $urandom; type_i = 3'($urandom);
            end
            dn = et ? done1 : done0;
            if (dn === 1'b1) begin
                nd++;
                if (cyc == 0) cyc = i;
            end
            if (cyc != 0 && i >= cyc + 2) break;
            tick();
        end
    endtask

    task automatic wait_idle();
        int k;
        k = 0;
        while ((busy0 || busy1) && k < 60) begin
            tick();
            k++;
        end
        checks++;
        if (busy0 || busy1) begin
            errors++;
            $display("FAIL wait_idle busy0=%b busy1=%b expected both 0", busy0, busy1);
        end
    endtask

    task automatic test_reset();
        reset = 1'b1; start = 1'b1; flush = 1'b1;
        type_i = 3'b100; a = 32'hDEAD_BEEF; b = 32'h1234_5678; c = 32'h1; d = 32'h2;
        tick();
        tick();
        checks++;
        if ({busy0, done0, n0, z0, u0, busy1, done1} !== 7'b0) begin
            errors++;
            $display("FAIL reset_flags got %b expected 0000000", {busy0, done0, n0, z0, u0, busy1, done1});
        end
        checks++;
        if (res0 !== 64'd0 || res1 !== 64'd0) begin
            errors++;
            $display("FAIL reset_result got %h/%h expected 0", res0, res1);
        end
        reset = 1'b0; start = 1'b0; flush = 1'b0;
        tick();
        checks++;
        if (busy0 !== 1'b0) begin
            errors++;
            $display("FAIL reset_no_start busy=%b expected 0", busy0);
        end
    endtask

    task automatic test_latency();
        issue(3'b000, 32'd7, 32'd6, 32'd0, 32'd0);
        for (int i = 1; i <= 5; i++) begin
            checks++;
            if (busy0 !== 1'b1 || done0 !== 1'b0) begin
                errors++;
                $display("FAIL latency_busy cycle %0d busy=%b done=%b expected 1/0", i, busy0, done0);
            end
            tick();
        end
        checks++;
        if (done0 !== 1'b1 || res0 !== 64'd42 || n0 !== 1'b0 || z0 !== 1'b0) begin
            errors++;
            $display("FAIL latency_done cycle 6 done=%b result=%h n=%b z=%b expected 1/42/0/0", done0, res0, n0, z0);
        end
        tick();
        checks++;
        if (done0 !== 1'b0 || busy0 !== 1'b0) begin
            errors++;
            $display("FAIL latency_after done=%b busy=%b expected 0/0", done0, busy0);
        end
        wait_idle();
    endtask

    task automatic test_directed();
        logic [2:0]  ops [7];
        logic [31:0] va [7];
        logic [31:0] vb [7];
        logic [31:0] vc [7];
        logic [31:0] vd [7];
        logic [63:0] er [7];
        logic [2:0]  enzu [7];
        int lat [7];
        int cyc, nd;
        ops  = '{3'b110, 3'b000, 3'b101, 3'b111, 3'b001, 3'b010, 3'b011};
        va   = '{32'hFFFF_FFFF, 32'h0001_0000, 32'hFFFF_FFFF, 32'hFFFF_FFFD, 32'd5, 32'd9, 32'd9};
        vb   = '{32'd2, 32'h0001_0000, 32'hFFFF_FFFF, 32'd4, 32'd6, 32'd9, 32'd9};
        vc   = '{32'd0, 32'd0, 32'd1, 32'd0, 32'hFFFF_FFFF, 32'd1, 32'd1};
        vd   = '{32'd0, 32'd0, 32'd0, 32'd12, 32'd7, 32'd1, 32'd1};
        er   = '{64'hFFFF_FFFF_FFFF_FFFE, 64'd0, 64'hFFFF_FFFF_0000_0001, 64'd0, 64'd29, 64'd0, 64'd0};
        enzu = '{3'b100, 3'b010, 3'b100, 3'b010, 3'b000, 3'b011, 3'b011};
        lat  = '{6, 6, 6, 6, 6, 2, 2};
        for (int t = 0; t < 7; t++) begin
            issue(ops[t], va[t], vb[t], vc[t], vd[t]);
            wait_done(1'b0, 1'b0, 1, cyc, nd);
            checks++;
            if (cyc != lat[t] || nd != 1) begin
                errors++;
                $display("FAIL directed_%0d_timing done cycle %0d count %0d expected %0d/1", t, cyc, nd, lat[t]);
            end
            checks++;
            if (res0 !== er[t] || {n0, z0, u0} !== enzu[t]) begin
                errors++;
                $display("FAIL directed_%0d result=%h nzu=%b expected %h/%b", t, res0, {n0, z0, u0}, er[t], enzu[t]);
            end
            wait_idle();
        end
    endtask

    task automatic test_random();
        logic [2:0]  op;
        logic [31:0] ra, rb, rc, rd;
        logic [63:0] er;
        int cyc, nd, el;
        for (int t = 0; t < 60; t++) begin
            op = 3'($urandom_range(0, 7));
            ra = $urandom; rb = $urandom; rc = $urandom; rd = $urandom;
            if (t % 4 == 1) rb = rb >> $urandom_range(0, 31);
            if (t % 7 == 3) ra = 32'd0;
            er = ref_result(op, ra, rb, rc, rd);
            el = ref_latency(1'b0, op, rb);
            issue(op, ra, rb, rc, rd);
            wait_done(1'b0, 1'b1, 1, cyc, nd);
            checks++;
            if (cyc != el || nd != 1) begin
                errors++;
                $display("FAIL random_%0d_timing op=%b done cycle %0d count %0d expected %0d/1", t, op, cyc, nd, el);
            end
            checks++;
            if (res0 !== er || n0 !== ref_n(op, er) || z0 !== ref_z(op, er) || u0 !== (op[2:1] == 2'b01)) begin
                errors++;
                $display("FAIL random_%0d op=%b a=%h b=%h c=%h d=%h result=%h nzu=%b expected %h/%b%b%b",
                         t, op, ra, rb, rc, rd, res0, {n0, z0, u0}, er, ref_n(op, er), ref_z(op, er), op[2:1] == 2'b01);
            end
            wait_idle();
        end
    endtask

    task automatic test_early_term();
        logic [2:0]  op;
        logic [31:0] ra, rb, rc, rd;
        logic [63:0] er;
        int cyc, nd, el;
        issue(3'b000, 32'd3, 32'd5, 32'd0, 32'd0);
        wait_done(1'b1, 1'b0, 1, cyc, nd);
        checks++;
        if (cyc != 3 || nd != 1 || res1 !== 64'd15) begin
            errors++;
            $display("FAIL et_3x5 done cycle %0d count %0d result %h expected 3/1/15", cyc, nd, res1);
        end
        wait_idle();
        issue(3'b000, 32'h100, 32'h0101_0101, 32'd0, 32'd0);
        tick();
        type_i = 3'b000; a = 32'd9; b = 32'd9; start = 1'b1;
        tick();
        start = 1'b0;
        wait_done(1'b1, 1'b0, 3, cyc, nd);
        checks++;
        if (cyc != 6 || nd != 1 || res1 !== 64'h0101_0100) begin
            errors++;
            $display("FAIL et_ignore_start done cycle %0d count %0d result %h expected 6/1/01010100", cyc, nd, res1);
        end
        wait_idle();
        for (int t = 0; t < 30; t++) begin
            op = 3'($urandom_range(0, 7));
            ra = $urandom; rc = $urandom; rd = $urandom;
            rb = $urandom >> (8 * $urandom_range(0, 4));
            if (t % 5 == 2) rb = 32'hFFFF_FFFF - (rb & 32'hFF);
            er = ref_result(op, ra, rb, rc, rd);
            el = ref_latency(1'b1, op, rb);
            issue(op, ra, rb, rc, rd);
            wait_done(1'b1, 1'b1, 1, cyc, nd);
            checks++;
            if (cyc != el || nd != 1 || res1 !== er || n1 !== ref_n(op, er) || z1 !== ref_z(op, er)) begin
                errors++;
                $display("FAIL et_random_%0d op=%b b=%h done cycle %0d count %0d result %h expected %0d/1/%h",
                         t, op, rb, cyc, nd, res1, el, er);
            end
            wait_idle();
        end
    endtask

    task automatic test_back_to_back();
        logic [63:0] e1, e2;
        int cyc, nd;
        e1 = ref_result(3'b100, 32'h8000_0001, 32'h0000_0003, 32'd0, 32'd0);
        e2 = ref_result(3'b111, 32'h7654_3210, 32'h8765_4321, 32'h1111_1111, 32'h2222_2222);
        issue(3'b100, 32'h8000_0001, 32'h0000_0003, 32'd0, 32'd0);
        type_i = 3'b111; a = 32'h7654_3210; b = 32'h8765_4321; c = 32'h1111_1111; d = 32'h2222_2222;
        start = 1'b1;
        for (int i = 1; i <= N + 2; i++) begin
            checks++;
            if (done0 !== (i == N + 2)) begin
                errors++;
                $display("FAIL b2b_held_start cycle %0d done=%b expected %b", i, done0, i == N + 2);
            end
            tick();
        end
        checks++;
        if (busy0 !== 1'b0 || res0 !== e1) begin
            errors++;
            $display("FAIL b2b_done_cycle_start busy=%b result=%h expected 0/%h", busy0, res0, e1);
        end
        tick();
        start = 1'b0;
        checks++;
        if (busy0 !== 1'b1) begin
            errors++;
            $display("FAIL b2b_idle_accept busy=%b expected 1", busy0);
        end
        wait_done(1'b0, 1'b0, 1, cyc, nd);
        checks++;
        if (cyc != N + 2 || nd != 1 || res0 !== e2) begin
            errors++;
            $display("FAIL b2b_second done cycle %0d count %0d result %h expected %0d/1/%h", cyc, nd, res0, N + 2, e2);
        end
        wait_idle();
    endtask

    task automatic test_flush();
        int cyc, nd;
        issue(3'b000, 32'd7, 32'd6, 32'd0, 32'd0);
        wait_done(1'b0, 1'b0, 1, cyc, nd);
        wait_idle();
        issue(3'b100, 32'hABCD_1234, 32'h5555_AAAA, 32'd0, 32'd0);
        tick();
        flush = 1'b1;
        tick();
        flush = 1'b0;
        checks++;
        if (busy0 !== 1'b0 || done0 !== 1'b0) begin
            errors++;
            $display("FAIL flush_idle busy=%b done=%b expected 0/0", busy0, done0);
        end
        wait_done(1'b0, 1'b0, 1, cyc, nd);
        checks++;
        if (nd != 0 || res0 !== 64'd42 || z0 !== 1'b0) begin
            errors++;
            $display("FAIL flush_no_done count %0d result %h z=%b expected 0/42/0", nd, res0, z0);
        end
        start = 1'b1; flush = 1'b1;
        tick();
        start = 1'b0; flush = 1'b0;
        checks++;
        if (busy0 !== 1'b0) begin
            errors++;
            $display("FAIL flush_over_start busy=%b expected 0", busy0);
        end
        issue(3'b110, 32'h1234_5678, 32'h8000_0000, 32'd0, 32'd0);
        tick();
        tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        checks++;
        if (busy0 !== 1'b0 || done0 !== 1'b0 || res0 !== 64'd0 || {n0, z0, u0} !== 3'b000) begin
            errors++;
            $display("FAIL reset_mid_op busy=%b done=%b result=%h nzu=%b expected 0/0/0/000", busy0, done0, res0, {n0, z0, u0});
        end
        wait_done(1'b0, 1'b0, 1, cyc, nd);
        checks++;
        if (nd != 0) begin
            errors++;
            $display("FAIL reset_no_done count %0d expected 0", nd);
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL global_timeout simulation did not finish");
        $fatal(1);
    end

    initial begin
        reset = 1'b1; start = 1'b0; flush = 1'b0;
        type_i = 3'b000; a = '0; b = '0; c = '0; d = '0;
        test_reset();
        test_latency();
        test_directed();
        test_random();
        test_early_term();
        test_back_to_back();
        test_flush();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/multiply_unit.md
MULTIPLY_UNIT -- requirements
Module: multiply_unit

Interface
REQ-001 SHALL have parameter WIDTH, default 32: operand width in bits, >= 8.
REQ-002 SHALL have parameter STEP_BITS, default 8: multiplier bits consumed per cycle; WIDTH % STEP_BITS == 0.
REQ-003 SHALL have parameter EARLY_TERM, default 0: 1 enables early exit from iteration.
REQ-004 SHALL have port clk  input  1  the single clock; all state changes on its rising edge.
REQ-005 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-006 SHALL have port start  input  1  request; accepted only in IDLE.
REQ-007 SHALL have port flush  input  1  synchronous cancel of any operation in flight.
REQ-008 SHALL have port type  input  3  operation: 000 MUL, 001 MLA, 100 UMULL, 101 UMLAL, 110 SMULL, 111 SMLAL.
REQ-009 SHALL have ports a, b  input  WIDTH  multiplicand and multiplier; b is iterated.
REQ-010 SHALL have ports c, d  input  WIDTH  accumulator: MLA uses c; long forms use {c,d}, c high.
REQ-011 SHALL have port busy  output  1  high in every state except IDLE.
REQ-012 SHALL have port done  output  1  one-cycle pulse; result valid.
REQ-013 SHALL have port result  output  2*WIDTH  product; held from done until the next accepted start.
REQ-014 SHALL have ports n, z  output  1  sign and zero flags of result; undef  output  1  type was 010/011.

Function
REQ-015 SHALL sample all operands and type on the accepting start edge; later input changes have no effect.
REQ-016 SHALL implement FSM IDLE -> MUL -> FIX -> DONE -> IDLE.
REQ-017 MUL SHALL last N = WIDTH/STEP_BITS cycles, adding a * (next STEP_BITS of |b|) shifted into a 2*WIDTH partial sum.
REQ-018 With EARLY_TERM=1, MUL SHALL exit once the remaining |b| bits are all zero, after a minimum of one cycle.
REQ-019 Signed types SHALL multiply magnitudes and negate the product in FIX if the operand signs differ.
REQ-020 FIX SHALL add the accumulator: c zero-extended (MLA), {c,d} unsigned (UMLAL), or {c,d} two's complement (SMLAL), modulo 2^(2*WIDTH).
REQ-021 MUL/MLA SHALL be unsigned, keep the low WIDTH bits, and zero result[2*WIDTH-1:WIDTH].
REQ-022 n SHALL be the msb of the valid width (WIDTH for MUL/MLA, else 2*WIDTH); z SHALL be 1 iff all valid-width bits are zero.
REQ-023 DONE SHALL assert done for exactly one cycle and update result/n/z on entry to DONE.
REQ-024 Latency with EARLY_TERM=0 SHALL be: start accepted at edge k, done high in cycle k+N+2.
REQ-025 start while busy SHALL be ignored, with no queuing.
REQ-026 For type 010/011, SHALL skip MUL, set result=0, z=1, n=0, undef=1, and pulse done two cycles after acceptance.
REQ-027 flush SHALL return the FSM to IDLE next cycle with no done pulse and result unchanged; flush overrides start in the same cycle.
REQ-028 A start in the DONE cycle SHALL be ignored; a start in the first IDLE cycle after DONE SHALL be accepted.

Reset
REQ-029 On reset SHALL enter IDLE and drive busy=0, done=0, result=0, n=0, z=0, undef=0; reset overrides start and flush.
REQ-030 Reset mid-operation SHALL discard the operation without a done pulse.

Structure
REQ-031 The shared package SHALL hold the type encodings (MUL, MLA, UMULL, UMLAL, SMULL, SMLAL) and the FSM state enum, for reuse by decode.
REQ-032 SHALL contain one sub-module, mul_step, a combinational WIDTH x STEP_BITS partial-product adder.
REQ-033 SHALL contain no memories and no multi-cycle paths; the result register is the only wide output state.

Verification (WIDTH=32, STEP_BITS=8, N=4)
REQ-034 MUL a=7 b=6 at edge 0 -> done in cycle 6, result=42, n=0, z=0, busy high for cycles 1-5.
REQ-035 SMULL a=0xFFFFFFFF b=2 -> result=0xFFFFFFFF_FFFFFFFE, n=1; MUL a=0x10000 b=0x10000 -> result=0, z=1.
REQ-036 UMLAL a=b=0xFFFFFFFF c=1 d=0 -> result=0xFFFFFFFF_00000001; SMLAL a=-3 b=4 c=0 d=12 -> result=0.
REQ-037 EARLY_TERM=1, MUL a=3 b=5 at edge 0 -> done in cycle 3, result=15; a second start during busy -> ignored, one done only.
REQ-038 flush in cycle 2 of MUL, then reset mid-op on a second operation -> no done pulse, busy=0 next cycle, result keeps the last completed value, and is 0 after reset.
